// File: rtl/sim_usb_host_tx_if.sv
// Byte-stream and line-side bundle of the simulation USB host transmitter.
// txInjectStuffErr exists only when SIM_USB_TX_STUFF_ERR_INJECT_EN is defined.
interface sim_usb_host_tx_if;
  logic       txReqSendPacket;
  logic       txAcceptNewData;
  logic       txDataValid;
  logic       txIsLastByte;
  logic [7:0] txData;
  logic       sending;
  logic       txUnderrun;
  logic       USB_DP;
  logic       USB_DN;
`ifdef SIM_USB_TX_STUFF_ERR_INJECT_EN
  logic       txInjectStuffErr;
`endif

  modport master (
`ifdef SIM_USB_TX_STUFF_ERR_INJECT_EN
    output txInjectStuffErr,
`endif
    output txReqSendPacket, txDataValid, txIsLastByte, txData,
    input  txAcceptNewData, sending, txUnderrun, USB_DP, USB_DN
  );

  modport slave (
`ifdef SIM_USB_TX_STUFF_ERR_INJECT_EN
    input  txInjectStuffErr,
`endif
    input  txReqSendPacket, txDataValid, txIsLastByte, txData,
    output txAcceptNewData, sending, txUnderrun, USB_DP, USB_DN
  );
endinterface

// File: rtl/sim_usb_host_tx.sv
// Simulation USB host transmitter: SYNC, bit-stuffed NRZI data, EOP, with underrun detection.
// Optional stuff-error injection enabled by SIM_USB_TX_STUFF_ERR_INJECT_EN.
module sim_usb_host_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_BITS    = 8,
  parameter int EOP_SE0_BITS = 2,
  parameter int EOP_J_BITS   = 1,
  parameter int STUFF_RUN    = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  sim_usb_host_tx_if.slave  bus
);
  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = 16;
  localparam int STF_W = $clog2(STUFF_RUN + 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STF_W-1:0] stuff_q, stuff_d;
  logic [7:0]       shift_q, shift_d, hold_q, hold_d;
  logic             hold_full_q, hold_full_d, last_seen_q, last_seen_d;
  logic             hold_inj_q, hold_inj_d, shift_inj_q, shift_inj_d;
  logic             req_pend_q, req_pend_d;
  logic             line_k_q, line_k_d, se0_q, se0_d;
  logic             underrun_q, underrun_d;
  logic             bit_tick, accept, xfer, inj_in, stuff_due, emit, emit_raw;

`ifdef SIM_USB_TX_STUFF_ERR_INJECT_EN
  assign inj_in = bus.txInjectStuffErr;
`else
  assign inj_in = 1'b0;
`endif

  assign bit_tick  = (div_q == DIV_W'(CLKS_PER_BIT - 1));
  assign accept    = ((state_q == S_SYNC) || (state_q == S_DATA)) && !hold_full_q && !last_seen_q;
  assign xfer      = bus.txDataValid && accept;
  // Injected bytes leave the run counter saturated so the violation is visible on the line.
  assign stuff_due = (stuff_q == STF_W'(STUFF_RUN)) && !((state_q == S_DATA) && shift_inj_q);

  assign bus.txAcceptNewData = accept;
  assign bus.sending         = (state_q != S_IDLE);
  assign bus.txUnderrun      = underrun_q;
  assign bus.USB_DP          = !se0_q && !line_k_q;
  assign bus.USB_DN          = !se0_q && line_k_q;

  always_comb begin
    state_d     = state_q;
    div_d       = bit_tick ? '0 : div_q + 1'b1;
    cnt_d       = cnt_q;
    stuff_d     = stuff_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_seen_d = last_seen_q;
    hold_inj_d  = hold_inj_q;
    shift_inj_d = shift_inj_q;
    req_pend_d  = req_pend_q;
    line_k_d    = line_k_q;
    se0_d       = se0_q;
    underrun_d  = 1'b0;
    emit        = 1'b0;
    emit_raw    = 1'b0;

    if (xfer) begin
      hold_d      = bus.txData;
      hold_full_d = 1'b1;
      last_seen_d = bus.txIsLastByte;
      hold_inj_d  = inj_in;
    end
    if ((state_q == S_IDLE) && bus.txReqSendPacket) req_pend_d = 1'b1;

    if (bit_tick) begin
      case (state_q)
        S_IDLE: begin
          if (bus.txReqSendPacket || req_pend_q) begin
            state_d    = S_SYNC;
            cnt_d      = '0;
            req_pend_d = 1'b0;
            emit       = 1'b1;
            emit_raw   = (SYNC_BITS == 1);
          end
        end
        S_SYNC, S_DATA: begin
          if (stuff_due) begin
            emit = 1'b1;
          end else if ((state_q == S_SYNC) && (cnt_q != CNT_W'(SYNC_BITS - 1))) begin
            cnt_d    = cnt_q + 1'b1;
            emit     = 1'b1;
            emit_raw = (cnt_d == CNT_W'(SYNC_BITS - 1));
          end else if ((state_q == S_DATA) && (cnt_q != CNT_W'(7))) begin
            cnt_d    = cnt_q + 1'b1;
            shift_d  = {1'b0, shift_q[7:1]};
            emit     = 1'b1;
            emit_raw = shift_q[1];
          end else if (hold_full_q) begin
            state_d     = S_DATA;
            cnt_d       = '0;
            shift_d     = hold_q;
            shift_inj_d = hold_inj_q;
            hold_full_d = 1'b0;
            emit        = 1'b1;
            emit_raw    = hold_q[0];
          end else begin
            state_d    = S_EOP_SE0;
            cnt_d      = '0;
            se0_d      = 1'b1;
            stuff_d    = '0;
            underrun_d = !last_seen_q || (state_q == S_SYNC);
          end
        end
        S_EOP_SE0: begin
          if (cnt_q != CNT_W'(EOP_SE0_BITS - 1)) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d  = S_EOP_J;
            cnt_d    = '0;
            se0_d    = 1'b0;
            line_k_d = 1'b0;
          end
        end
        S_EOP_J: begin
          if (cnt_q != CNT_W'(EOP_J_BITS - 1)) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            hold_full_d = 1'b0;
            last_seen_d = 1'b0;
            hold_inj_d  = 1'b0;
            shift_inj_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // NRZI: raw 0 toggles J/K, raw 1 holds; the run counter tracks raw 1s.
    if (emit) begin
      se0_d = 1'b0;
      if (!emit_raw) begin
        line_k_d = !line_k_q;
        stuff_d  = '0;
      end else begin
        stuff_d = (stuff_q == STF_W'(STUFF_RUN)) ? stuff_q : stuff_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      stuff_q     <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_seen_q <= 1'b0;
      hold_inj_q  <= 1'b0;
      shift_inj_q <= 1'b0;
      req_pend_q  <= 1'b0;
      line_k_q    <= 1'b0;
      se0_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      stuff_q     <= stuff_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_seen_q <= last_seen_d;
      hold_inj_q  <= hold_inj_d;
      shift_inj_q <= shift_inj_d;
      req_pend_q  <= req_pend_d;
      line_k_q    <= line_k_d;
      se0_q       <= se0_d;
      underrun_q  <= underrun_d;
    end
  end
endmodule

// File: tb/tb_sim_usb_host_tx.sv
// Self-checking bench for sim_usb_host_tx: a symbol-level packet model predicts
// the per-clock DP/DN/sending/underrun waveform, checked every falling edge.
module tb_sim_usb_host_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sim_usb_host_tx_if bus ();

  sim_usb_host_tx dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int ph = 0;
  bit chk_en = 1'b0;
  logic [3:0] exp_q[$];          // {dp, dn, sending, underrun} per clock
  logic [7:0] drv_q[$];
  bit drv_last = 1'b0;
  int snd_cnt = 0;
  int und_cnt = 0;
  int acc_cnt = 0;
  logic acc_snd = 1'b0;

  // Packet model: raw bits -> stuffed bits -> NRZI symbols (J, K, 0 = SE0).
  function automatic string line_of(input logic [7:0] b[$]);
    bit raw[$];
    string s = "";
    bit k = 1'b0;
    int run = 0;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    foreach (b[i]) for (int j = 0; j < 8; j++) raw.push_back(b[i][j]);
    foreach (raw[i]) begin
      if (!raw[i]) k = !k;
      if (k) s = {s, "K"}; else s = {s, "J"};
      run = raw[i] ? run + 1 : 0;
      if (run == 6) begin
        k = !k;
        if (k) s = {s, "K"}; else s = {s, "J"};
        run = 0;
      end
    end
    s = {s, "00J"};
    return s;
  endfunction

  task automatic plan(input string s, input bit under, input int lead);
    bit first_se0 = 1'b1;
    for (int i = 0; i < lead; i++) exp_q.push_back(4'b1000);
    for (int i = 0; i < s.len(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        logic [3:0] e;
        case (s[i])
          "K":     e = 4'b0110;
          "J":     e = 4'b1010;
          default: e = 4'b0010;
        endcase
        if (s[i] == "0" && first_se0 && c == 0) begin
          e[0] = under;
          first_se0 = 1'b0;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive();
    if (drv_q.size() > 0) begin
      bus.txDataValid  = 1'b1;
      bus.txData       = drv_q[0];
      bus.txIsLastByte = (drv_q.size() == 1) && drv_last;
    end else begin
      bus.txDataValid  = 1'b0;
      bus.txData       = 8'h00;
      bus.txIsLastByte = 1'b0;
    end
    if (bus.txDataValid && bus.txAcceptNewData) begin
      void'(drv_q.pop_front());
      acc_cnt++;
      acc_snd = bus.sending;
    end
  endtask

  task automatic step();
    @(posedge clk);
    ph = !rst_n ? 0 : (ph + 1) % CPB;
    #1;
    drive();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_str(input string name, input string got, input string want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %s want %s", name, got, want);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: %0d expected cycles left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_packet(input string name, input logic [7:0] b[$], input bit last,
                            input int n_sent, input bit under, input int want_snd);
    logic [7:0] sent[$];
    for (int i = 0; i < n_sent; i++) sent.push_back(b[i]);
    drv_q    = b;
    drv_last = last;
    snd_cnt  = 0;
    und_cnt  = 0;
    acc_cnt  = 0;
    bus.txReqSendPacket = 1'b1;
    plan(line_of(sent), under, 1 + (CPB - 1 - ph));
    step();
    bus.txReqSendPacket = 1'b0;
    wait_done(name);
    repeat (6) step();
    check_int({name, " sending_clks"}, snd_cnt, want_snd);
    check_int({name, " underrun_pulses"}, und_cnt, under ? 1 : 0);
    $display("packet %s: bytes_sent=%0d sending_clks=%0d underruns=%0d", name, n_sent, snd_cnt, und_cnt);
    drv_q.delete();
  endtask

  // Compare process: every falling edge while checking is enabled.
  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] got;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1000;
      got = {bus.USB_DP, bus.USB_DN, bus.sending, bus.txUnderrun};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL line t=%0t: dp/dn/snd/und got %b want %b", $time, got, e);
      end
      if (!e[1]) begin
        checks++;
        if (bus.txAcceptNewData !== 1'b0) begin
          errors++;
          $display("FAIL accept_idle t=%0t: got %b want 0", $time, bus.txAcceptNewData);
        end
      end
    end
    if (bus.sending === 1'b1) snd_cnt++;
    if (bus.txUnderrun === 1'b1) und_cnt++;
  end

  initial begin
    logic [7:0] pk[$];
    logic [7:0] mq[$];
    bus.txReqSendPacket = 1'b0;
    bus.txDataValid     = 1'b0;
    bus.txIsLastByte    = 1'b0;
    bus.txData          = 8'h00;
`ifdef SIM_USB_TX_STUFF_ERR_INJECT_EN
    bus.txInjectStuffErr = 1'b0;
`endif

    // Reset held for 3 cycles; idle line checked from the first reset edge on.
    step();
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    $display("reset: released after 3 cycles");
    repeat (5) step();

    // Pin the model against hand-derived symbol streams.
    mq.delete(); mq.push_back(8'hA5);
    check_str("model_A5", line_of(mq), "KJKJKJKKKJJKJJKK00J");
    mq.delete(); mq.push_back(8'hFF);
    check_str("model_FF", line_of(mq), "KJKJKJKKKKKKKJJJJ00J");
    mq.delete(); mq.push_back(8'h12);
    check_str("model_12", line_of(mq), "KJKJKJKKJJKJJKJK00J");
    mq.delete(); mq.push_back(8'h00); mq.push_back(8'h3C);
    check_int("model_two_len", line_of(mq).len(), 27);

    pk.delete(); pk.push_back(8'hA5);
    run_packet("A5", pk, 1'b1, 1, 1'b0, 76);

    pk.delete(); pk.push_back(8'hFF);
    run_packet("FF_stuff", pk, 1'b1, 1, 1'b0, 80);

    pk.delete(); pk.push_back(8'h00); pk.push_back(8'h3C);
    run_packet("two_bytes", pk, 1'b1, 2, 1'b0, 108);
    check_int("two_bytes accepted", acc_cnt, 2);
    check_int("two_bytes second_during_send", int'(acc_snd), 1);

    pk.delete(); pk.push_back(8'h12);
    run_packet("starve_12", pk, 1'b0, 1, 1'b1, 76);

    // Mid-packet reset: start A5, cut it during DATA, then a clean packet.
    pk.delete(); pk.push_back(8'hA5);
    drv_q = pk;
    drv_last = 1'b1;
    bus.txReqSendPacket = 1'b1;
    plan(line_of(pk), 1'b0, 1 + (CPB - 1 - ph));
    step();
    bus.txReqSendPacket = 1'b0;
    repeat (50) step();
    rst_n  = 1'b0;
    chk_en = 1'b0;
    exp_q.delete();
    drv_q.delete();
    step();
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    $display("mid_reset: reset applied during DATA");
    repeat (4) step();
    run_packet("after_reset", pk, 1'b1, 1, 1'b0, 76);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
